// File: rtl/riscv_issue_queue_ooo.sv
// Out-of-order issue queue: age-ordered circular buffer with writeback
// wakeup, oldest-ready select and branch-mispredict squash.
module riscv_issue_queue_ooo #(
  parameter int DEPTH     = 16,
  parameter int PTR_W     = 4,
  parameter int PAYLOAD_W = 128,
  parameter int TAG_W     = 4,
  parameter int WB_CH     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_val,
  output logic                 enq_rdy,
  input  logic [PAYLOAD_W-1:0] enq_payload,
  input  logic [4:0]           enq_rs1,
  input  logic [4:0]           enq_rs2,
  input  logic                 enq_rs1_rdy,
  input  logic                 enq_rs2_rdy,
  input  logic [TAG_W-1:0]     enq_tag,
  input  logic [WB_CH-1:0]     wb_val,
  input  logic [5*WB_CH-1:0]   wb_rd,
  output logic                 iss_val,
  input  logic                 iss_rdy,
  output logic [PAYLOAD_W-1:0] iss_payload,
  output logic [TAG_W-1:0]     iss_tag,
  output logic [PTR_W-1:0]     iss_slot,
  input  logic                 flush_val,
  input  logic [PTR_W-1:0]     flush_slot,
  output logic [PTR_W:0]       occupancy,
  output logic                 empty
);

  typedef logic [PTR_W-1:0] idx_t;
  typedef logic [PTR_W:0]   ptr_t;

  ptr_t                 r_head;
  ptr_t                 r_tail;
  logic [DEPTH-1:0]     r_valid;
  logic [DEPTH-1:0]     r_rs1_rdy;
  logic [DEPTH-1:0]     r_rs2_rdy;
  logic [4:0]           r_rs1 [DEPTH];
  logic [4:0]           r_rs2 [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [TAG_W-1:0]     r_tag [DEPTH];

  ptr_t             w_occ;
  idx_t             w_fo;
  idx_t             w_age [DEPTH];
  logic [DEPTH-1:0] w_kill;
  logic [DEPTH-1:0] w_cand;
  logic [DEPTH-1:0] w_nvalid;
  logic             w_found;
  idx_t             w_sel;
  logic             w_iss_fire;
  logic             w_enq_fire;
  idx_t             w_tail_idx;
  ptr_t             w_tail_base;
  ptr_t             w_span;
  ptr_t             w_head_nx;
  logic             w_hfound;

  function automatic logic f_hit(
    input logic [4:0]         rs,
    input logic [WB_CH-1:0]   val,
    input logic [5*WB_CH-1:0] rd
  );
    f_hit = 1'b0;
    for (int k = 0; k < WB_CH; k++) begin
      if (val[k] && rd[5*k +: 5] == rs && rs != 5'd0)
        f_hit = 1'b1;
    end
  endfunction

  assign w_occ       = r_tail - r_head;
  assign occupancy   = w_occ;
  assign empty       = (w_occ == '0);
  assign enq_rdy     = (w_occ < ptr_t'(DEPTH)) && !flush_val;
  assign w_enq_fire  = enq_val && enq_rdy;
  assign w_tail_idx  = r_tail[PTR_W-1:0];
  assign w_fo        = flush_slot - r_head[PTR_W-1:0];
  // Surviving tail sits just past the branch, measured from head.
  assign w_tail_base = flush_val ? (r_head + {1'b0, w_fo} + ptr_t'(1))
                                 : r_tail;
  assign w_span      = w_tail_base - r_head;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_age[j]  = idx_t'(j) - r_head[PTR_W-1:0];
      w_kill[j] = flush_val && (w_age[j] > w_fo);
      w_cand[j] = r_valid[j] && r_rs1_rdy[j] &&
                  r_rs2_rdy[j] && !w_kill[j];
    end
  end

  always_comb begin
    idx_t s_idx;
    s_idx   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s_idx = r_head[PTR_W-1:0] + idx_t'(i);
      if (!w_found && w_cand[s_idx]) begin
        w_found = 1'b1;
        w_sel   = s_idx;
      end
    end
  end

  assign iss_val     = w_found;
  assign iss_payload = w_found ? r_payload[w_sel] : '0;
  assign iss_tag     = w_found ? r_tag[w_sel] : '0;
  assign iss_slot    = w_found ? w_sel : '0;
  assign w_iss_fire  = w_found && iss_rdy;

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_nvalid[j] = r_valid[j] && !w_kill[j] &&
                    !(w_iss_fire && (w_sel == idx_t'(j)));
    end
  end

  // Head skips every hole left by issue or flush in one step.
  always_comb begin
    idx_t h_idx;
    h_idx     = '0;
    w_hfound  = 1'b0;
    w_head_nx = w_tail_base;
    for (int i = 0; i < DEPTH; i++) begin
      h_idx = r_head[PTR_W-1:0] + idx_t'(i);
      if (!w_hfound && (ptr_t'(i) < w_span) && w_nvalid[h_idx]) begin
        w_hfound  = 1'b1;
        w_head_nx = r_head + ptr_t'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_valid   <= '0;
      r_rs1_rdy <= '0;
      r_rs2_rdy <= '0;
    end else begin
      r_head  <= w_head_nx;
      r_tail  <= w_enq_fire ? (r_tail + ptr_t'(1)) : w_tail_base;
      r_valid <= w_nvalid;
      for (int j = 0; j < DEPTH; j++) begin
        if (f_hit(r_rs1[j], wb_val, wb_rd)) r_rs1_rdy[j] <= 1'b1;
        if (f_hit(r_rs2[j], wb_val, wb_rd)) r_rs2_rdy[j] <= 1'b1;
      end
      if (w_enq_fire) begin
        r_valid[w_tail_idx]   <= 1'b1;
        r_rs1_rdy[w_tail_idx] <= enq_rs1_rdy || (enq_rs1 == 5'd0) ||
                                 f_hit(enq_rs1, wb_val, wb_rd);
        r_rs2_rdy[w_tail_idx] <= enq_rs2_rdy || (enq_rs2 == 5'd0) ||
                                 f_hit(enq_rs2, wb_val, wb_rd);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_payload[w_tail_idx] <= enq_payload;
      r_tag[w_tail_idx]     <= enq_tag;
      r_rs1[w_tail_idx]     <= enq_rs1;
      r_rs2[w_tail_idx]     <= enq_rs2;
    end
  end

  a_flush_occupied: assert property (
    @(posedge clk) disable iff (reset)
    flush_val |-> ({1'b0, w_fo} < w_occ)
  );

endmodule

// File: tb/tb_riscv_issue_queue_ooo.sv
// Scenario bench for riscv_issue_queue_ooo with an issue-order scoreboard.
module tb_riscv_issue_queue_ooo;

  logic         clk;
  logic         reset;
  logic         enq_val;
  logic         enq_rdy;
  logic [127:0] enq_payload;
  logic [4:0]   enq_rs1;
  logic [4:0]   enq_rs2;
  logic         enq_rs1_rdy;
  logic         enq_rs2_rdy;
  logic [3:0]   enq_tag;
  logic [1:0]   wb_val;
  logic [9:0]   wb_rd;
  logic         iss_val;
  logic         iss_rdy;
  logic [127:0] iss_payload;
  logic [3:0]   iss_tag;
  logic [3:0]   iss_slot;
  logic         flush_val;
  logic [3:0]   flush_slot;
  logic [4:0]   occupancy;
  logic         empty;

  int n_pass;
  int n_total;
  logic [3:0] exp_q [$];

  riscv_issue_queue_ooo dut (
    .clk(clk), .reset(reset),
    .enq_val(enq_val), .enq_rdy(enq_rdy),
    .enq_payload(enq_payload),
    .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
    .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
    .enq_tag(enq_tag),
    .wb_val(wb_val), .wb_rd(wb_rd),
    .iss_val(iss_val), .iss_rdy(iss_rdy),
    .iss_payload(iss_payload), .iss_tag(iss_tag),
    .iss_slot(iss_slot),
    .flush_val(flush_val), .flush_slot(flush_slot),
    .occupancy(occupancy), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted issue must match the next expected tag.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!reset && iss_val && iss_rdy) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected got tag=%0d expected none",
                 iss_tag);
      end else begin
        e = exp_q.pop_front();
        if (iss_tag !== e || iss_payload !== {32{e}})
          $display("FAIL sb_issue got tag=%0d expected tag=%0d",
                   iss_tag, e);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_val   = 1'b0;
    wb_val    = 2'b00;
    wb_rd     = '0;
    flush_val = 1'b0;
  endtask

  task automatic reset_pulse();
    idle();
    iss_rdy = 1'b0;
    reset   = 1'b1;
    #2;
    reset   = 1'b0;
  endtask

  task automatic enq(input logic [3:0] t,
                     input logic [4:0] r1, input logic k1,
                     input logic [4:0] r2, input logic k2);
    enq_val     = 1'b1;
    enq_tag     = t;
    enq_payload = {32{t}};
    enq_rs1     = r1;
    enq_rs1_rdy = k1;
    enq_rs2     = r2;
    enq_rs2_rdy = k2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    iss_rdy = 1'b0;
    enq(4'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    enq_val = 1'b0;
    flush_slot = '0;
    #3;
    n_total++;
    if (iss_val !== 1'b0 || iss_tag !== 4'd0 || iss_slot !== 4'd0 ||
        iss_payload !== '0)
      $display("FAIL reset_iss got val=%b tag=%0d slot=%0d expected 0",
               iss_val, iss_tag, iss_slot);
    else n_pass++;
    n_total++;
    if (occupancy !== 5'd0 || empty !== 1'b1 || enq_rdy !== 1'b1)
      $display("FAIL reset_status got occ=%0d empty=%b rdy=%b expected 0/1/1",
               occupancy, empty, enq_rdy);
    else n_pass++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_inorder();
    iss_rdy = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      enq(4'(t), 5'd1, 1'b1, 5'd2, 1'b1);
      exp_q.push_back(4'(t));
      tick();
    end
    enq_val = 1'b0;
    tick();
    @(negedge clk);
    n_total++;
    if (occupancy !== 5'd0 || empty !== 1'b1 || iss_val !== 1'b0)
      $display("FAIL inorder_drain got occ=%0d empty=%b val=%b expected 0/1/0",
               occupancy, empty, iss_val);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL inorder_count got pending=%0d expected 0", exp_q.size());
    else n_pass++;
    tick();
  endtask

  task automatic test_wakeup();
    iss_rdy = 1'b1;
    enq(4'd4, 5'd5, 1'b0, 5'd0, 1'b0);
    tick();
    enq(4'd5, 5'd7, 1'b1, 5'd8, 1'b1);
    exp_q.push_back(4'd5);
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b0)
      $display("FAIL wake_blocked got val=%b expected 0", iss_val);
    else n_pass++;
    tick();
    enq(4'd6, 5'd5, 1'b0, 5'd0, 1'b0);
    wb_val = 2'b10;
    wb_rd  = {5'd5, 5'd0};
    exp_q.push_back(4'd4);
    exp_q.push_back(4'd6);
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b1 || iss_slot !== 4'd4)
      $display("FAIL wake_b_first got val=%b slot=%0d expected 1/4",
               iss_val, iss_slot);
    else n_pass++;
    tick();
    idle();
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b1 || iss_slot !== 4'd3)
      $display("FAIL wake_a got val=%b slot=%0d expected 1/3",
               iss_val, iss_slot);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b1 || iss_slot !== 4'd5)
      $display("FAIL wake_bypass_c got val=%b slot=%0d expected 1/5",
               iss_val, iss_slot);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (empty !== 1'b1)
      $display("FAIL wake_empty got empty=%b expected 1", empty);
    else n_pass++;
    tick();
  endtask

  task automatic test_full();
    reset_pulse();
    for (int t = 0; t < 16; t++) begin
      enq(4'(t), (t == 0) ? 5'd1 : 5'd10, 1'b0, 5'd11, 1'b1);
      tick();
    end
    enq(4'd3, 5'd0, 1'b1, 5'd0, 1'b1);
    @(negedge clk);
    n_total++;
    if (enq_rdy !== 1'b0 || occupancy !== 5'd16 || iss_val !== 1'b0)
      $display("FAIL full_state got rdy=%b occ=%0d val=%b expected 0/16/0",
               enq_rdy, occupancy, iss_val);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (occupancy !== 5'd16 || iss_val !== 1'b0)
      $display("FAIL full_refuse got occ=%0d val=%b expected 16/0",
               occupancy, iss_val);
    else n_pass++;
    enq_val = 1'b0;
    wb_val  = 2'b01;
    wb_rd   = {5'd0, 5'd1};
    tick();
    wb_val  = 2'b00;
    iss_rdy = 1'b1;
    exp_q.push_back(4'd0);
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b1 || iss_slot !== 4'd0)
      $display("FAIL full_wake got val=%b slot=%0d expected 1/0",
               iss_val, iss_slot);
    else n_pass++;
    tick();
    iss_rdy = 1'b0;
    @(negedge clk);
    n_total++;
    if (occupancy !== 5'd15 || enq_rdy !== 1'b1)
      $display("FAIL full_after_issue got occ=%0d rdy=%b expected 15/1",
               occupancy, enq_rdy);
    else n_pass++;
    enq(4'd12, 5'd0, 1'b1, 5'd0, 1'b1);
    tick();
    enq_val = 1'b0;
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b1 || iss_slot !== 4'd0 || iss_tag !== 4'd12 ||
        occupancy !== 5'd16)
      $display("FAIL full_wrap got val=%b slot=%0d tag=%0d occ=%0d expected 1/0/12/16",
               iss_val, iss_slot, iss_tag, occupancy);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    reset_pulse();
    iss_rdy = 1'b1;
    enq(4'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    exp_q.push_back(4'd0);
    tick();
    enq(4'd1, 5'd0, 1'b1, 5'd0, 1'b1);
    exp_q.push_back(4'd1);
    tick();
    enq(4'd2, 5'd10, 1'b0, 5'd0, 1'b1);
    tick();
    iss_rdy = 1'b0;
    for (int t = 3; t <= 9; t++) begin
      enq(4'(t), (t == 3 || t == 7) ? 5'd0 : 5'd10,
          (t == 3 || t == 7), 5'd0, 1'b1);
      tick();
    end
    enq(4'd13, 5'd0, 1'b1, 5'd0, 1'b1);
    flush_val  = 1'b1;
    flush_slot = 4'd4;
    iss_rdy    = 1'b1;
    exp_q.push_back(4'd3);
    @(negedge clk);
    n_total++;
    if (occupancy !== 5'd8 || enq_rdy !== 1'b0 ||
        iss_val !== 1'b1 || iss_slot !== 4'd3)
      $display("FAIL flush_cycle got occ=%0d rdy=%b val=%b slot=%0d expected 8/0/1/3",
               occupancy, enq_rdy, iss_val, iss_slot);
    else n_pass++;
    tick();
    idle();
    iss_rdy = 1'b0;
    @(negedge clk);
    n_total++;
    if (occupancy !== 5'd3 || iss_val !== 1'b0)
      $display("FAIL flush_after got occ=%0d val=%b expected 3/0",
               occupancy, iss_val);
    else n_pass++;
    enq(4'd14, 5'd0, 1'b1, 5'd0, 1'b1);
    tick();
    enq_val = 1'b0;
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b1 || iss_slot !== 4'd5 || iss_tag !== 4'd14)
      $display("FAIL flush_new_tail got val=%b slot=%0d tag=%0d expected 1/5/14",
               iss_val, iss_slot, iss_tag);
    else n_pass++;
    flush_val  = 1'b1;
    flush_slot = 4'd4;
    #1;
    n_total++;
    if (iss_val !== 1'b0)
      $display("FAIL flush_mask got val=%b expected 0", iss_val);
    else n_pass++;
    tick();
    flush_val = 1'b0;
    @(negedge clk);
    n_total++;
    if (occupancy !== 5'd3)
      $display("FAIL flush_mask_occ got occ=%0d expected 3", occupancy);
    else n_pass++;
    tick();
  endtask

  task automatic test_head_jump();
    reset_pulse();
    enq(4'd0, 5'd20, 1'b0, 5'd0, 1'b1);
    tick();
    enq(4'd1, 5'd0, 1'b1, 5'd0, 1'b1);
    exp_q.push_back(4'd1);
    tick();
    enq(4'd2, 5'd0, 1'b1, 5'd0, 1'b1);
    exp_q.push_back(4'd2);
    tick();
    enq(4'd3, 5'd21, 1'b0, 5'd0, 1'b1);
    tick();
    enq_val = 1'b0;
    iss_rdy = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b0 || occupancy !== 5'd4)
      $display("FAIL jump_holes got val=%b occ=%0d expected 0/4",
               iss_val, occupancy);
    else n_pass++;
    wb_val = 2'b01;
    wb_rd  = {5'd0, 5'd20};
    exp_q.push_back(4'd0);
    tick();
    wb_val = 2'b00;
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b1 || iss_slot !== 4'd0)
      $display("FAIL jump_head_issue got val=%b slot=%0d expected 1/0",
               iss_val, iss_slot);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (occupancy !== 5'd1 || iss_val !== 1'b0)
      $display("FAIL jump_result got occ=%0d val=%b expected 1/0",
               occupancy, iss_val);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    iss_rdy = 1'b0;
    wb_val  = 2'b01;
    wb_rd   = {5'd0, 5'd21};
    tick();
    wb_val = 2'b00;
    @(negedge clk);
    n_total++;
    if (iss_val !== 1'b1 || iss_slot !== 4'd3)
      $display("FAIL areset_pre got val=%b slot=%0d expected 1/3",
               iss_val, iss_slot);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (iss_val !== 1'b0 || empty !== 1'b1 ||
        enq_rdy !== 1'b1 || occupancy !== 5'd0)
      $display("FAIL areset_async got val=%b empty=%b rdy=%b occ=%0d expected 0/1/1/0",
               iss_val, empty, enq_rdy, occupancy);
    else n_pass++;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_inorder();
    test_wakeup();
    test_full();
    test_flush();
    test_head_jump();
    test_async_reset();
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL sb_leftover got pending=%0d expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/riscv_issue_queue_ooo.md
Name: riscv_issue_queue_ooo

Overview:
- Parametrised out-of-order issue queue between decode and the execute pipes.
- Holds up to DEPTH decoded instructions in a circular age-ordered buffer, one entry per enqueue.
- Tracks source-operand readiness through WB_CH writeback wakeup channels.
- Issues the oldest ready entry each cycle and squashes entries younger than a mispredicted branch.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- PTR_W, 4, log2(DEPTH); pointers are PTR_W+1 bits, with the extra wrap bit used for full/empty.
- PAYLOAD_W, 128, opaque payload bits (ir, cs, pc, pc_plus4 concatenated by the instantiator).
- TAG_W, 4, ROB slot tag width.
- WB_CH, 2, number of writeback wakeup channels.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enq_val  in  1  decode offers an instruction
- enq_rdy  out  1  queue accepts; high when occupancy < DEPTH and flush_val low
- enq_payload  in  PAYLOAD_W  instruction payload
- enq_rs1, enq_rs2  in  5 each  source register ids
- enq_rs1_rdy, enq_rs2_rdy  in  1 each  scoreboard says operand already available
- enq_tag  in  TAG_W  ROB fill slot
- wb_val  in  WB_CH  per-channel writeback valid
- wb_rd  in  5*WB_CH  per-channel destination reg; channel k occupies bits [5k+4:5k]
- iss_val  out  1  an entry is selected for issue
- iss_rdy  in  1  execute accepts
- iss_payload  out  PAYLOAD_W  selected entry payload
- iss_tag  out  TAG_W  selected entry ROB tag
- iss_slot  out  PTR_W  selected entry index
- flush_val  in  1  branch mispredict squash
- flush_slot  in  PTR_W  IQ slot of the mispredicting branch; it survives, strictly younger entries die
- occupancy  out  PTR_W+1  tail minus head, including issued holes
- empty  out  1  occupancy == 0

Behaviour:
- **Reset** (async, any cycle, including mid-flush or mid-issue):
  - head = tail = 0; all valid and ready bits 0.
  - Payload contents are don't-care.
  - Outputs: iss_val 0, iss_payload/iss_tag/iss_slot 0, occupancy 0, empty 1, enq_rdy 1.
- **Enqueue** fires on enq_val && enq_rdy:
  - Writes the tail entry, sets valid, tail += 1 (wraps naturally via the extra bit).
  - Each operand is stored as ready if its _rdy input is set, OR its reg id == 0, OR it matches any wb_rd with wb_val set in the same cycle (same-cycle wakeup bypass).
- **Wakeup**: every cycle, each valid entry sets rsN ready when any channel has wb_val[k] && wb_rd[k] == rsN && rsN != 0. Multiple matching channels are harmless.
- **Select** (combinational, registered state only; wakeups become visible the following cycle):
  - Scan from head toward tail.
  - Pick the first entry with valid && rs1 ready && rs2 ready.
  - iss_val = found; outputs are driven from that entry. When not found, iss_payload, iss_tag and iss_slot are 0.
- **Issue** fires on iss_val && iss_rdy: clears the selected entry's valid. The entry becomes a hole, and occupancy is unchanged until head passes it.
- **Head advance** each cycle, computed after this cycle's issue and flush updates:
  - head moves to the oldest still-valid entry in [head, tail).
  - If none remain, head moves to tail.
  - There is no one-per-cycle limit.
- **Full**: occupancy == DEPTH drops enq_rdy. Holes still count until head passes them.
- **Flush** (flush_val):
  - All entries from flush_slot+1 up to tail-1 are invalidated.
  - tail is set to flush_slot+1, with the wrap bit chosen so the new tail lies between head and the old tail.
  - enq_rdy is 0 that cycle, so no enqueue occurs.
  - The select mask excludes entries younger than flush_slot combinationally, so iss_val only reflects survivors.
  - If flush_slot is not an occupied position, behaviour is undefined; an assertion fires.
- **Simultaneous issue and flush**: permitted when the issued entry survives the flush.
- **Simultaneous issue and head advance**: head may skip the just-issued slot in the same cycle.
- **Latency**: enqueue-to-earliest-issue is 1 cycle, provided the entry's operands are ready.

Test Plan:
- Reset, then enqueue 3 entries with both operands ready (tags 1, 2, 3), iss_rdy=1 -> issue order tags 1, 2, 3 on consecutive cycles; occupancy returns to 0; empty=1.
- Enqueue A (rs1=5, not ready), then B (ready) -> B issues first. Assert wb_val[1] with wb_rd=5 -> A issues the next cycle. Enqueue C (rs1=5) while wb_rd=5 is asserted -> C is stored ready.
- Fill 16 entries with no operand ready -> enq_rdy=0, occupancy=16. Wake slot 0 and issue it -> head advances, occupancy 15, enq_rdy=1. Wrap: next enqueue lands in slot 0.
- Occupied slots 2..9, flush_val with flush_slot=4 -> slots 5..9 invalid, tail=5, occupancy 3; the same-cycle enqueue is refused. A ready slot 7 is not issued; ready slot 3 issues in the same cycle.
- Issued holes at slots 0..2 with slot 3 valid -> head jumps from 0 to 3 in one cycle.
- Assert reset asynchronously mid-stream with iss_val=1 -> iss_val drops without waiting for a clock edge; empty=1, enq_rdy=1 immediately.
